marquee_scroller: RTL and testbench

Parametrised scrolling-text engine for seven-segment display banks, the next generation of our fixed six-digit scrolling-message design. It holds a writable message of raw segment patterns and scrolls it across `DIGITS` displays at a programmable rate. It adds run/pause, single-step, direction control, a runtime message length and step/wrap status pulses. It sits between the 50 MHz board clock and the display pins and replaces the separate prescaler, counter, message ROM and shift chain.

---
 rtl/marquee_scroller.sv | 98 +++++++++
 tb/tb_marquee_scroller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/marquee_scroller.sv
// Scrolling seven-segment message engine: a writable pattern RAM is shifted
// across DIGITS displays on prescaler ticks or on demand, in either direction.
module marquee_scroller #(
   parameter int DIGITS     = 6,
   parameter int MSG_LEN    = 16,
   parameter int RATE_DIV   = 49999999,
   parameter int ACTIVE_LOW = 1,
   localparam int LEN_W     = $clog2(MSG_LEN + 1),
   localparam int ADDR_W    = $clog2(MSG_LEN)
) (
   input  logic                  CLK50,
   input  logic                  RST,
   input  logic                  run,
   input  logic                  dir,
   input  logic                  step_req,
   input  logic [LEN_W-1:0]      len,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [6:0]            wr_data,
   output logic [7*DIGITS-1:0]   seg,
   output logic                  step,
   output logic                  wrap
);

   localparam int CNT_W = (RATE_DIV > 0) ? $clog2(RATE_DIV + 1) : 1;
   localparam int SEG_W = 7 * DIGITS;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [SEG_W-1:0]  disp_q, disp_d;
   logic              step_q;
   logic              wrap_q, wrap_d;
   logic [6:0]        mem_q [MSG_LEN];

   logic              tick;
   logic              adv;
   logic              len_zero;
   logic              ptr_oob;
   logic [ADDR_W-1:0] rd_idx;
   logic [ADDR_W-1:0] last_idx;
   logic [6:0]        enter;

   // advance decision, entering pattern and next-state
   always_comb begin
      tick     = (cnt_q == CNT_W'(RATE_DIV));
      adv      = (tick && run) || step_req;
      cnt_d    = (tick || step_req) ? '0 : cnt_q + CNT_W'(1);
      len_zero = (len == '0);
      ptr_oob  = (LEN_W'(ptr_q) >= len);
      last_idx = ADDR_W'(len - LEN_W'(1));
      // a pointer left beyond a shortened message restarts from index 0
      rd_idx   = ptr_oob ? '0 : ptr_q;
      enter    = len_zero ? 7'd0 : mem_q[rd_idx];

      ptr_d  = ptr_q;
      disp_d = disp_q;
      wrap_d = 1'b0;
      if (adv) begin
         if (dir) disp_d = {enter, disp_q[SEG_W-1:7]};
         else     disp_d = {disp_q[SEG_W-8:0], enter};

         if (len_zero)   ptr_d = '0;
         else if (ptr_oob) ptr_d = (len == LEN_W'(1)) ? '0 : ADDR_W'(1);
         else if (!dir)  ptr_d = (ptr_q == last_idx) ? '0 : ptr_q + ADDR_W'(1);
         else            ptr_d = (ptr_q == '0) ? last_idx : ptr_q - ADDR_W'(1);

         wrap_d = !len_zero && (dir ? (rd_idx == '0) : (rd_idx == last_idx));
      end
   end

   // state registers
   always_ff @(posedge CLK50) begin
      if (RST) begin
         cnt_q  <= '0;
         ptr_q  <= '0;
         disp_q <= '0;
         step_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         ptr_q  <= ptr_d;
         disp_q <= disp_d;
         step_q <= adv;
         wrap_q <= wrap_d;
      end
   end

   // message RAM: read is combinational from the old contents, so a same-edge
   // write to the read address is seen only on a later advance
   always_ff @(posedge CLK50) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   assign seg  = (ACTIVE_LOW != 0) ? ~disp_q : disp_q;
   assign step = step_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_marquee_scroller.sv
// Bench for marquee_scroller: a cycle model built from the scrolling rules plus
// directed scenarios with hand-computed display values.
module tb_marquee_scroller;

   localparam int RATE_DIV = 3;

   logic        CLK50 = 1'b0;
   logic        RST, run, dir, step_req, wr_en;
   logic [3:0]  len;
   logic [2:0]  wr_addr;
   logic [6:0]  wr_data;
   logic [27:0] seg;
   logic        step, wrap;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [6:0] pat [8] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h7F};
   logic [6:0] lp  [4] = '{7'h01, 7'h02, 7'h04, 7'h01};
   logic       lw  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
   logic [6:0] dp  [4] = '{7'h01, 7'h04, 7'h02, 7'h01};
   logic       dw  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   marquee_scroller #(
      .DIGITS(4), .MSG_LEN(8), .RATE_DIV(RATE_DIV), .ACTIVE_LOW(1)
   ) dut (
      .CLK50(CLK50), .RST(RST), .run(run), .dir(dir), .step_req(step_req),
      .len(len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .seg(seg), .step(step), .wrap(wrap)
   );

   always #5 CLK50 = ~CLK50;

   // inputs as seen by the DUT at each rising edge
   logic       s_rst, s_run, s_dir, s_req, s_wen;
   logic [3:0] s_len;
   logic [2:0] s_waddr;
   logic [6:0] s_wdata;
   always @(posedge CLK50) begin
      s_rst   <= RST;
      s_run   <= run;
      s_dir   <= dir;
      s_req   <= step_req;
      s_wen   <= wr_en;
      s_len   <= len;
      s_waddr <= wr_addr;
      s_wdata <= wr_data;
   end

   // behavioural model, advanced and compared on every falling edge
   initial begin : model
      int         cnt, ptr, idx, L;
      logic [6:0] ent;
      logic [6:0] md [4];
      logic [6:0] mr [8];
      logic       mstep, mwrap, on, adv, tck;
      logic [27:0] e;
      on = 1'b0; cnt = 0; ptr = 0; mstep = 1'b0; mwrap = 1'b0;
      for (int k = 0; k < 4; k++) md[k] = '0;
      for (int k = 0; k < 8; k++) mr[k] = '0;
      forever begin
         @(negedge CLK50);
         if (s_rst) begin
            on = 1'b1; cnt = 0; ptr = 0; mstep = 1'b0; mwrap = 1'b0;
            for (int k = 0; k < 4; k++) md[k] = '0;
         end else begin
            L   = int'(s_len);
            tck = (cnt == RATE_DIV);
            adv = (tck && s_run) || s_req;
            cnt = (tck || s_req) ? 0 : cnt + 1;
            mstep = adv;
            mwrap = 1'b0;
            if (adv) begin
               ent = '0;
               if (L > 0) begin
                  idx   = (ptr < L) ? ptr : 0;
                  ent   = mr[idx];
                  mwrap = s_dir ? (idx == 0) : (idx == L - 1);
                  if (ptr >= L)   ptr = 1 % L;
                  else if (s_dir) ptr = (idx + L - 1) % L;
                  else            ptr = (idx + 1) % L;
               end else begin
                  ptr = 0;
               end
               if (!s_dir) begin
                  for (int k = 3; k > 0; k--) md[k] = md[k-1];
                  md[0] = ent;
               end else begin
                  for (int k = 0; k < 3; k++) md[k] = md[k+1];
                  md[3] = ent;
               end
            end
         end
         if (s_wen) mr[s_waddr] = s_wdata;
         if (on) begin
            for (int k = 0; k < 4; k++) e[7*k +: 7] = md[k] ^ 7'h7F;
            n_cmp++;
            if (seg !== e) begin
               n_fail++;
               $display("FAIL model seg @%0t: got %07h expected %07h", $time, seg, e);
            end
            n_cmp++;
            if (step !== mstep) begin
               n_fail++;
               $display("FAIL model step @%0t: got %0b expected %0b", $time, step, mstep);
            end
            n_cmp++;
            if (wrap !== mwrap) begin
               n_fail++;
               $display("FAIL model wrap @%0t: got %0b expected %0b", $time, wrap, mwrap);
            end
         end
      end
   end

   task automatic cyc();
      @(negedge CLK50);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_step(input string name, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!step && n < 12);
      check({name, " step seen"}, 32'(step), 32'd1);
   endtask

   initial begin : stim
      int n;
      int steps;
      RST = 1'b1; run = 1'b1; dir = 1'b0; step_req = 1'b0; len = 4'd0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      cyc(); cyc();
      check("reset seg", 32'(seg), 32'h0FFFFFFF);
      check("reset step", 32'(step), 32'd0);
      check("reset wrap", 32'(wrap), 32'd0);

      RST = 1'b0;
      wait_step("first", n);
      check("first step latency", 32'(n), 32'd4);
      run = 1'b0;

      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_addr = i[2:0]; wr_data = pat[i];
         cyc();
      end
      wr_en = 1'b0;

      steps = 0;
      repeat (20) begin
         cyc();
         if (step) steps++;
      end
      check("pause steps", 32'(steps), 32'd0);

      len = 4'd3; dir = 1'b0; run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_step("left", n);
         check("left digit0", 32'(seg[6:0]), 32'(lp[i] ^ 7'h7F));
         check("left wrap", 32'(wrap), 32'(lw[i]));
      end
      check("left seg", 32'(seg), 32'h0FDF7DFE);
      run = 1'b0;

      step_req = 1'b1; cyc();
      check("step_req latency", 32'(step), 32'd1);
      check("step_req digit0", 32'(seg[6:0]), 32'h7D);
      step_req = 1'b0; cyc();
      check("step_req single", 32'(step), 32'd0);
      cyc(); cyc();
      check("paused no step", 32'(step), 32'd0);
      run = 1'b1; step_req = 1'b1; cyc();
      check("tick+req step", 32'(step), 32'd1);
      check("tick+req wrap", 32'(wrap), 32'd1);
      step_req = 1'b0; cyc();
      check("tick+req single", 32'(step), 32'd0);
      cyc(); cyc(); cyc();
      check("tick after req", 32'(step), 32'd1);
      check("tick after req digit0", 32'(seg[6:0]), 32'h7E);
      run = 1'b0;

      RST = 1'b1; cyc();
      check("mid reset seg", 32'(seg), 32'h0FFFFFFF);
      check("mid reset step", 32'(step), 32'd0);
      RST = 1'b0; dir = 1'b1; run = 1'b1; len = 4'd3;
      for (int i = 0; i < 4; i++) begin
         wait_step("dir", n);
         check("dir digit3", 32'(seg[27:21]), 32'(dp[i] ^ 7'h7F));
         check("dir wrap", 32'(wrap), 32'(dw[i]));
      end
      check("dir seg", 32'(seg), 32'h0FDF7DFE);

      len = 4'd0; dir = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_step("len0", n);
         check("len0 wrap", 32'(wrap), 32'd0);
      end
      check("len0 seg", 32'(seg), 32'h0FFFFFFF);

      run = 1'b0; RST = 1'b1; cyc();
      RST = 1'b0; len = 4'd8; dir = 1'b0; run = 1'b1;
      for (int i = 0; i < 5; i++) wait_step("len8", n);
      len = 4'd2;
      wait_step("len drop", n);
      check("len drop digit0", 32'(seg[6:0]), 32'h7E);
      check("len drop wrap", 32'(wrap), 32'd0);
      wait_step("len drop next", n);
      check("len drop next digit0", 32'(seg[6:0]), 32'h7D);
      check("len drop next wrap", 32'(wrap), 32'd1);
      run = 1'b0;

      step_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 7'h55; cyc();
      check("collision old", 32'(seg[6:0]), 32'h7E);
      step_req = 1'b0; wr_en = 1'b0; cyc();
      step_req = 1'b1; cyc();
      check("collision wrap", 32'(wrap), 32'd1);
      step_req = 1'b0; cyc();
      step_req = 1'b1; cyc();
      check("collision new", 32'(seg[6:0]), 32'h2A);
      step_req = 1'b0; cyc();

      len = 4'd1;
      step_req = 1'b1; cyc();
      check("len1 wrap a", 32'(wrap), 32'd1);
      step_req = 1'b0; cyc();
      step_req = 1'b1; cyc();
      check("len1 wrap b", 32'(wrap), 32'd1);
      step_req = 1'b0;
      repeat (3) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
